// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer, imem valid/ready request port and decode-side FIFO.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in HALT.
module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              fetch_misalign
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;
`else
    typedef enum logic {FETCH, DRAIN} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, tgt;
    logic [CW-1:0]     outst_q, outst_nx, count_q;
    logic [CW-1:0]     discard_q, discard_d;
    logic [PW-1:0]     tag_wr_q, tag_rd_q, wr_q, rd_q;
    logic [ADDR_W-1:0] tag_q [FIFO_DEPTH];
    fetch_entry_t      fifo_q [FIFO_DEPTH];
    logic              accept, resp_ok, push, pop;
    logic              flush, req_space;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign tgt            = redirect_pc;
    assign fetch_misalign = misalign_q;
`else
    assign tgt            = redirect_pc & ~ADDR_W'(3);
    assign fetch_misalign = 1'b0;
`endif

    // Reserve a FIFO slot for every in-flight response before issuing.
    assign req_space = ({1'b0, outst_q} + {1'b0, count_q})
                       < (CW+1)'(FIFO_DEPTH);

    assign imem_req_valid = reset && (state_q == FETCH)
                            && !redirect_valid && req_space;
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign resp_ok        = imem_resp_valid && (outst_q != '0);
    assign outst_nx       = outst_q - CW'(resp_ok);
    assign push           = resp_ok && (state_q == FETCH) && !redirect_valid;

    assign dec_valid = (count_q != '0);
    assign pop       = dec_valid && dec_ready && !redirect_valid;
    assign dec_instr = dec_valid ? fifo_q[rd_q].instr : '0;
    assign dec_pc    = dec_valid ? fifo_q[rd_q].pc : '0;

    always_comb begin
        state_d   = state_q;
        pc_d      = accept ? pc_q + ADDR_W'(4) : pc_q;
        discard_d = discard_q;
        flush     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    flush     = 1'b1;
                    pc_d      = tgt;
                    discard_d = outst_nx;
                    state_d   = (outst_nx != '0) ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                if (resp_ok && discard_q != '0)
                    discard_d = discard_q - CW'(1);
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = tgt;
                end
                if (discard_d == '0)
                    state_d = FETCH;
            end
            default: ;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_valid && (|redirect_pc[1:0]) && state_q != HALT) begin
            flush      = 1'b1;
            pc_d       = pc_q;
            misalign_d = 1'b1;
            state_d    = HALT;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            unique case (1'b1)
                accept && !resp_ok: outst_q <= outst_q + CW'(1);
                resp_ok && !accept: outst_q <= outst_q - CW'(1);
                default: ;
            endcase
            if (flush) begin
                count_q  <= '0;
                wr_q     <= '0;
                rd_q     <= '0;
                tag_wr_q <= '0;
                tag_rd_q <= '0;
            end else begin
                if (accept)
                    tag_wr_q <= tag_wr_q + PW'(1);
                if (push) begin
                    tag_rd_q <= tag_rd_q + PW'(1);
                    wr_q     <= wr_q + PW'(1);
                end
                if (pop)
                    rd_q <= rd_q + PW'(1);
                unique case (1'b1)
                    push && !pop: count_q <= count_q + CW'(1);
                    pop && !push: count_q <= count_q - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_q[tag_wr_q] <= pc_q;
        if (push)
            fifo_q[wr_q] <= '{instr: imem_resp_data, pc: tag_q[tag_rd_q]};
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            misalign_q <= 1'b0;
        else
            misalign_q <= misalign_d;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then randomized traffic,
// checked against a PC-stream model of memory, FIFO and redirects.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc;
    logic        fetch_misalign;

    fetch_unit #(
        .ADDR_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mem_mode = 0;  // 0: 1-cycle latency, 1: random latency, 2: hold
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: never
    logic [31:0] mq_addr[$];
    int          mq_cyc[$];
    int          live = 0;   // accepted since last redirect, not yet consumed
    int          stale = 0;  // memory responses owed to pre-redirect requests
    logic        halted = 1'b0;
    logic [31:0] exp_req = '0;
    logic [31:0] exp_dec = '0;
    int          n_acc = 0;
    int          n_pop = 0;
    int          mark;
    logic [31:0] a0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic exp_rv, exp_dv;
        int   fifo_n;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mq_addr.size() > 0 && mq_cyc[0] < cyc) begin
            if (mem_mode == 0 || (mem_mode == 1 && $urandom_range(1, 0) == 1)) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mq_addr[0]);
            end
        end
        case (rdy_mode)
            0: imem_req_ready = 1'b1;
            1: imem_req_ready = ($urandom_range(3, 0) != 0);
            default: imem_req_ready = 1'b0;
        endcase
        #1;
        fifo_n = live - (mq_addr.size() - stale);
        exp_rv = !halted && !redirect_valid && stale == 0 && live < DEPTH;
        exp_dv = !halted && fifo_n > 0;
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("dec_valid", 32'(dec_valid), 32'(exp_dv));
        if (imem_req_valid)
            check("req_addr", imem_req_addr, exp_req);
        if (dec_valid && dec_ready && !redirect_valid) begin
            check("dec_pc", dec_pc, exp_dec);
            check("dec_instr", dec_instr, mem_word(exp_dec));
            exp_dec += 32'd4;
            live--;
            n_pop++;
        end
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_cyc.push_back(cyc);
            exp_req += 32'd4;
            live++;
            n_acc++;
        end
        if (imem_resp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_cyc.pop_front());
            if (stale > 0) stale--;
        end
        if (redirect_valid && !halted) begin
            live  = 0;
            stale = mq_addr.size();
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
`endif
            exp_req = redirect_pc & ~32'h3;
            exp_dec = exp_req;
        end
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_dec_valid", 32'(dec_valid), 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_misalign", 32'(fetch_misalign), 32'h0);
        mq_addr.delete();
        mq_cyc.delete();
        live    = 0;
        stale   = 0;
        halted  = 1'b0;
        exp_req = '0;
        exp_dec = '0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'h1);
        check("first_req_addr", imem_req_addr, 32'h0);
    endtask

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        dec_ready       = 1'b1;
        @(negedge clk);
        do_reset();

        // back-to-back delivery with 1-cycle memory
        mem_mode = 0; rdy_mode = 0; dec_ready = 1'b1;
        mark = n_pop;
        for (int i = 0; i < 6; i++) step();
        check("t2_pops", 32'(n_pop - mark), 32'd4);

        // reset mid-run while traffic is flowing
        do_reset();
        for (int i = 0; i < 3; i++) step();

        // decode stalled: exactly DEPTH requests, then resume
        do_reset();
        dec_ready = 1'b0;
        mark = n_acc;
        for (int i = 0; i < 10; i++) step();
        check("t3_reqs", 32'(n_acc - mark), 32'd4);
        check("t3_stopped", 32'(imem_req_valid), 32'h0);
        dec_ready = 1'b1;
        check("t3_resume_addr", imem_req_addr, 32'h10);
        for (int i = 0; i < 8; i++) step();
        check("t3_resumed", 32'(n_acc - mark > 4), 32'h1);

        // redirect with two responses still outstanding
        do_reset();
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        mem_mode = 2;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        check("t4_flush", 32'(dec_valid), 32'h0);
        check("t4_stale", 32'(stale), 32'd2);
        mem_mode = 0; dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t4_progress", 32'(exp_dec > 32'h100), 32'h1);

        // memory not ready: address held
        do_reset();
        for (int i = 0; i < 3; i++) step();
        a0 = imem_req_addr;
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_addr_hold", imem_req_addr, a0);
        end
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) step();

        // misaligned redirect target
        do_reset();
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_misalign", 32'(fetch_misalign), 32'h1);
        for (int i = 0; i < 5; i++) step();
        check("t6_halted", 32'(imem_req_valid), 32'h0);
`else
        check("t6_misalign", 32'(fetch_misalign), 32'h0);
        for (int i = 0; i < 8; i++) step();
        check("t6_aligned", 32'(exp_dec > 32'h100), 32'h1);
`endif

        // randomized traffic with occasional redirects
        do_reset();
        mem_mode = 1; rdy_mode = 1;
        mark = n_pop;
        for (int i = 0; i < 3000; i++) begin
            dec_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(40, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(4, 0) == 0) ? 32'hFFFF_FFF0
                                                          : ($urandom & 32'h0000_FFFF);
`ifdef FETCH_ALIGN_CHECK_EN
                redirect_pc[1:0] = 2'b00;
`endif
            end
            step();
        end
        check("rand_progress", 32'(n_pop - mark > 300), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
